fx2_fifo_responder: RTL and testbench

Synthesizable model of the FX2LP slave-FIFO end of the link that comm_fpga_fx2 drives. It presents the fx2 pin set as a responder: EP2OUT (host>>FPGA) is filled from a local host byte stream, and EP6IN (FPGA>>host) is drained to a local host byte stream with USB packet commit semantics. It is used for board-less system simulation and for FPGA-to-FPGA loopback rigs in place of a real FX2LP.

---
 rtl/fx2_fifo_responder_pkg.sv | 8 +
 rtl/fx2_fifo_responder_if.sv | 12 +
 rtl/fx2_fifo_responder_ep_fifo.sv | 36 +++
 rtl/fx2_fifo_responder.sv | 70 +++++++
 tb/tb_fx2_fifo_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fx2_fifo_responder_pkg.sv
// fx2_pkg: shared constants for the FX2LP slave-FIFO responder
package fx2_pkg;
    localparam logic FIFOSEL_EP2OUT = 1'b0;
    localparam logic FIFOSEL_EP6IN  = 1'b1;
    localparam int EP2_AW_DEF  = 9;
    localparam int EP6_AW_DEF  = 9;
    localparam int PKT_LEN_DEF = 512;
endpackage

// File: rtl/fx2_fifo_responder_if.sv
// fx2_fifo_responder_if: FX2 slave-FIFO control pins (data bus is a separate inout)
interface fx2_fifo_responder_if;
    logic fifo_sel;
    logic read_n;
    logic oe_n;
    logic got_data;
    logic write_n;
    logic got_room;
    logic pkt_end_n;
    modport master (output fifo_sel, read_n, oe_n, write_n, pkt_end_n, input got_data, got_room);
    modport slave  (input fifo_sel, read_n, oe_n, write_n, pkt_end_n, output got_data, got_room);
endinterface

// File: rtl/fx2_fifo_responder_ep_fifo.sv
// fx2_ep_fifo: byte FIFO whose pop side only sees bytes released by commit
module fx2_ep_fifo #(
    parameter int AW = 9
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          commit,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic [AW:0]   committed
);
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nx;
    assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
    assign head = mem[rd_ptr];
    always_ff @(posedge clk_in)
        if (push) mem[wr_ptr] <= din;
    // commit releases everything held, including this edge's push
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            committed <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count_nx;
            committed <= commit ? count_nx : committed - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/fx2_fifo_responder.sv
// fx2_fifo_responder: FX2LP slave-FIFO stand-in bridging fx2 pins to local host byte streams
module fx2_fifo_responder
    import fx2_pkg::*;
#(
    parameter int EP2_AW  = EP2_AW_DEF,
    parameter int EP6_AW  = EP6_AW_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    fx2_fifo_responder_if.slave    fx2,
    inout  wire  [7:0]             fx2Data_io,
    input  logic [7:0]             hostData_in,
    input  logic                   hostValid_in,
    output logic                   hostReady_out,
    output logic [7:0]             hostData_out,
    output logic                   hostValid_out,
    input  logic                   hostReady_in,
    output logic                   overrun_out,
    output logic                   underrun_out
);
    logic            run;
    logic            ep2_sel, ep6_sel, rd, wr;
    logic            ep2_push, ep2_pop, ep6_push, ep6_pop, ep6_commit;
    logic [7:0]      ep2_head, ep6_head;
    logic [EP2_AW:0] ep2_count, ep2_cmt;
    logic [EP6_AW:0] ep6_count, ep6_cmt, pending_nx;

    assign ep2_sel = fx2.fifo_sel == FIFOSEL_EP2OUT;
    assign ep6_sel = fx2.fifo_sel == FIFOSEL_EP6IN;
    assign rd      = run & ep2_sel & !fx2.read_n;
    assign wr      = run & ep6_sel & !fx2.write_n;

    assign hostReady_out = run & !ep2_count[EP2_AW];
    assign ep2_push      = hostValid_in & hostReady_out;
    assign fx2.got_data  = run & (ep2_cmt != '0);
    assign ep2_pop       = rd & (ep2_cmt != '0);
    assign fx2Data_io    = (run & ep2_sel & !fx2.oe_n) ? ep2_head : 8'hzz;

    assign fx2.got_room = run & !ep6_count[EP6_AW];
    assign ep6_push     = wr & fx2.got_room;
    // pending includes the byte landing this edge, so auto-commit fires on the PKT_LEN-th write
    assign pending_nx   = ep6_count - ep6_cmt + (EP6_AW+1)'(ep6_push);
    assign ep6_commit   = (run & ep6_sel & !fx2.pkt_end_n) | (pending_nx == (EP6_AW+1)'(PKT_LEN));
    assign hostValid_out = run & (ep6_cmt != '0);
    assign hostData_out  = run ? ep6_head : 8'h00;
    assign ep6_pop       = hostValid_out & hostReady_in;

    fx2_ep_fifo #(.AW(EP2_AW)) u_ep2 (
        .clk_in(clk_in), .reset_in(reset_in), .push(ep2_push), .din(hostData_in), .pop(ep2_pop),
        .commit(1'b1), .head(ep2_head), .count(ep2_count), .committed(ep2_cmt)
    );

    fx2_ep_fifo #(.AW(EP6_AW)) u_ep6 (
        .clk_in(clk_in), .reset_in(reset_in), .push(ep6_push), .din(fx2Data_io), .pop(ep6_pop),
        .commit(ep6_commit), .head(ep6_head), .count(ep6_count), .committed(ep6_cmt)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            run          <= 1'b0;
            overrun_out  <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            run          <= 1'b1;
            overrun_out  <= overrun_out | (wr & !fx2.got_room);
            underrun_out <= underrun_out | (rd & (ep2_cmt == '0));
        end
    end
endmodule

// File: tb/tb_fx2_fifo_responder.sv
// tb_fx2_fifo_responder: scoreboard bench for both FX2 endpoints, flags and reset
module tb_fx2_fifo_responder;
    import fx2_pkg::*;
    localparam int AW = 4;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic [7:0] host_din = '0;
    logic       host_vin = 1'b0;
    logic       host_rdy;
    logic [7:0] host_dout;
    logic       host_vout;
    logic       host_rin = 1'b0;
    logic       overrun, underrun;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_dat = '0;
    wire  [7:0] fx2_data;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] ep2_q[$];
    logic [7:0] ep6_q[$];

    always #5 clk = ~clk;
    assign fx2_data = tb_drv ? tb_dat : 8'hzz;

    fx2_fifo_responder_if bus_if();

    fx2_fifo_responder #(.EP2_AW(AW), .EP6_AW(AW), .PKT_LEN(PL)) dut (
        .clk_in(clk), .reset_in(reset_in), .fx2(bus_if.slave), .fx2Data_io(fx2_data),
        .hostData_in(host_din), .hostValid_in(host_vin), .hostReady_out(host_rdy),
        .hostData_out(host_dout), .hostValid_out(host_vout), .hostReady_in(host_rin),
        .overrun_out(overrun), .underrun_out(underrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_push(input logic [7:0] b);
        chk("host_ready", host_rdy, 1);
        host_din = b;
        host_vin = 1'b1;
        ep2_q.push_back(b);
        @(negedge clk);
        host_vin = 1'b0;
    endtask

    task automatic ep2_read();
        bus_if.fifo_sel = FIFOSEL_EP2OUT;
        bus_if.oe_n = 1'b0;
        #1;
        if (ep2_q.size() == 0) chk("ep2_sb_empty", 1, 0);
        else chk("ep2_data", fx2_data, ep2_q.pop_front());
        bus_if.read_n = 1'b0;
        @(negedge clk);
        bus_if.read_n = 1'b1;
        bus_if.oe_n = 1'b1;
    endtask

    task automatic fx2_write(input logic [7:0] b, input logic pe, input logic keep);
        bus_if.fifo_sel = FIFOSEL_EP6IN;
        tb_drv = 1'b1;
        tb_dat = b;
        bus_if.write_n = 1'b0;
        bus_if.pkt_end_n = !pe;
        if (keep) ep6_q.push_back(b);
        @(negedge clk);
        bus_if.write_n = 1'b1;
        bus_if.pkt_end_n = 1'b1;
        tb_drv = 1'b0;
    endtask

    task automatic pkt_end(input logic sel);
        bus_if.fifo_sel = sel;
        bus_if.pkt_end_n = 1'b0;
        @(negedge clk);
        bus_if.pkt_end_n = 1'b1;
    endtask

    task automatic drain();
        host_rin = 1'b1;
        for (int c = 0; c < 200 && ep6_q.size() > 0; c++) begin
            if (host_vout) chk("ep6_data", host_dout, ep6_q.pop_front());
            @(negedge clk);
        end
        host_rin = 1'b0;
        chk("ep6_drain_left", ep6_q.size(), 0);
        chk("ep6_valid_after_drain", host_vout, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_got_data"}, bus_if.got_data, 0);
        chk({tag, "_got_room"}, bus_if.got_room, 0);
        chk({tag, "_host_ready"}, host_rdy, 0);
        chk({tag, "_host_valid"}, host_vout, 0);
        chk({tag, "_host_data"}, host_dout, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus_if.fifo_sel = FIFOSEL_EP2OUT;
        bus_if.read_n = 1'b1;
        bus_if.oe_n = 1'b1;
        bus_if.write_n = 1'b1;
        bus_if.pkt_end_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset_in = 1'b1;
        @(negedge clk);
        chk("live_got_room", bus_if.got_room, 1);
        chk("live_got_data", bus_if.got_data, 0);

        host_push(8'h11);
        chk("ep2_got_data_latency", bus_if.got_data, 1);
        host_push(8'h22);
        host_push(8'h33);
        repeat (3) ep2_read();
        chk("ep2_got_data_empty", bus_if.got_data, 0);

        for (int i = 0; i < PL; i++) begin
            fx2_write(8'(8'hA0 + i), 1'b0, 1'b1);
            chk("ep6_valid_autocommit", host_vout, 32'(i == PL - 1));
        end
        drain();

        fx2_write(8'h55, 1'b0, 1'b1);
        chk("early_pending_hidden", host_vout, 0);
        fx2_write(8'h66, 1'b1, 1'b1);
        chk("early_committed", host_vout, 1);
        drain();
        pkt_end(FIFOSEL_EP6IN);
        chk("zlp_no_valid", host_vout, 0);

        for (int i = 0; i < 2**AW; i++) fx2_write(8'(i * 7 + 1), 1'b0, 1'b1);
        chk("full_got_room", bus_if.got_room, 0);
        chk("full_overrun_clear", overrun, 0);
        fx2_write(8'hEE, 1'b0, 1'b0);
        chk("overrun_set", overrun, 1);
        chk("full_valid", host_vout, 1);
        host_rin = 1'b1;
        chk("full_first_byte", host_dout, ep6_q.pop_front());
        @(negedge clk);
        host_rin = 1'b0;
        chk("room_after_pop", bus_if.got_room, 1);
        drain();

        chk("underrun_clear", underrun, 0);
        bus_if.fifo_sel = FIFOSEL_EP2OUT;
        bus_if.read_n = 1'b0;
        @(negedge clk);
        bus_if.read_n = 1'b1;
        chk("underrun_set", underrun, 1);
        chk("underrun_got_data", bus_if.got_data, 0);
        host_push(8'h77);
        ep2_read();

        tb_drv = 1'b1;
        tb_dat = 8'h99;
        bus_if.fifo_sel = FIFOSEL_EP2OUT;
        bus_if.write_n = 1'b0;
        @(negedge clk);
        bus_if.write_n = 1'b1;
        tb_drv = 1'b0;
        pkt_end(FIFOSEL_EP6IN);
        chk("wrong_sel_write_ignored", host_vout, 0);

        host_push(8'h88);
        bus_if.fifo_sel = FIFOSEL_EP6IN;
        bus_if.read_n = 1'b0;
        @(negedge clk);
        bus_if.read_n = 1'b1;
        chk("wrong_sel_read_ignored", bus_if.got_data, 1);
        ep2_read();
        chk("ep2_empty_again", bus_if.got_data, 0);

        fx2_write(8'hC1, 1'b0, 1'b1);
        pkt_end(FIFOSEL_EP2OUT);
        chk("wrong_sel_pktend_ignored", host_vout, 0);
        pkt_end(FIFOSEL_EP6IN);
        chk("pktend_commit", host_vout, 1);
        drain();

        fx2_write(8'hB0, 1'b0, 1'b1);
        fx2_write(8'hB1, 1'b0, 1'b1);
        fx2_write(8'hB2, 1'b1, 1'b1);
        fx2_write(8'hB3, 1'b0, 1'b0);
        fx2_write(8'hB4, 1'b0, 1'b0);
        host_push(8'hD0);
        chk("pre_reset_valid", host_vout, 1);
        reset_in = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        ep2_q.delete();
        ep6_q.delete();
        reset_in = 1'b1;
        @(negedge clk);
        chk("post_reset_got_room", bus_if.got_room, 1);
        chk("post_reset_valid", host_vout, 0);
        chk("post_reset_got_data", bus_if.got_data, 0);
        pkt_end(FIFOSEL_EP6IN);
        chk("post_reset_pending_gone", host_vout, 0);
        fx2_write(8'h5A, 1'b1, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
